// File: rtl/stream_frame_capture.sv
// rtl/stream_frame_capture.sv - arm-triggered single-frame stream capture into block RAM
module stream_frame_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] stream_i_tdata,
  input  logic                  stream_i_tvalid,
  output logic                  stream_i_tready,
  input  logic                  stream_i_tlast,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   frame_len,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL_LEN  = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DROP    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]     frame_len_q, frame_len_d;
  logic                    overflow_q, overflow_d;
  logic                    arm_old_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic arm_edge;
  logic accept;
  logic wr_en;

  // Ready depends only on state so the upstream never sees a combinational path from tvalid.
  assign stream_i_tready = (state_q == S_CAPTURE) || (state_q == S_DROP);
  assign accept          = stream_i_tvalid && stream_i_tready;
  assign arm_edge        = arm && !arm_old_q;
  // A beat accepted in CAPTURE is always stored, even if abort arrives in the same cycle.
  assign wr_en           = (state_q == S_CAPTURE) && accept;

  assign busy      = stream_i_tready;
  assign done      = (state_q == S_DONE);
  assign frame_len = frame_len_q;
  assign overflow  = overflow_q;
  assign rd_data   = rd_data_q;

  // Next-state and capture bookkeeping.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frame_len_d = frame_len_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_edge) begin
          state_d     = S_CAPTURE;
          wr_ptr_d    = '0;
          frame_len_d = '0;
          overflow_d  = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (stream_i_tlast) begin
            frame_len_d = wr_ptr_q + 1'b1;
            state_d     = S_DONE;
          end else if (wr_ptr_q == LAST_ADDR) begin
            overflow_d = 1'b1;
            state_d    = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept && stream_i_tlast) begin
          frame_len_d = FULL_LEN;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; arm history is tracked in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      frame_len_q <= '0;
      overflow_q  <= 1'b0;
      arm_old_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_len_q <= frame_len_d;
      overflow_q  <= overflow_d;
      arm_old_q   <= arm;
    end
  end

  // Sample buffer write; contents survive reset. The pointer never reaches DEPTH while writing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= stream_i_tdata;
    end
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_stream_frame_capture.sv
// tb/tb_stream_frame_capture.sv - directed bench for stream_frame_capture at two buffer depths
module tb_stream_frame_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [9:0]  rd_addr_b = '0;
  logic [2:0]  rd_addr_s = '0;

  logic        tready_b, busy_b, done_b, ovf_b;
  logic [15:0] rd_data_b;
  logic [10:0] flen_b;
  logic        tready_s, busy_s, done_s, ovf_s;
  logic [15:0] rd_data_s;
  logic [3:0]  flen_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_frame_capture #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) u_big (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .stream_i_tdata(tdata), .stream_i_tvalid(tvalid), .stream_i_tready(tready_b),
    .stream_i_tlast(tlast), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .frame_len(flen_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  stream_frame_capture #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u_small (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .stream_i_tdata(tdata), .stream_i_tvalid(tvalid), .stream_i_tready(tready_s),
    .stream_i_tlast(tlast), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .frame_len(flen_s), .busy(busy_s), .done(done_s), .overflow(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic arm_pulse();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  // Offers n beats base..base+n-1; tlast on the final beat when use_last. Returns cycles used.
  task automatic send(input int n, input int base, input bit rnd, input bit use_last,
                      output int cyc);
    int i;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 400) begin
      @(negedge clk);
      tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tdata  = 16'(base + i);
      tlast  = use_last && (i == n - 1);
      chk("tready_match", 32'(tready_b), 32'(tready_s));
      if (tvalid && tready_s) i++;
      cyc++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("send_budget", 32'(i), 32'(n));
  endtask

  task automatic read_s(input int addr, input int exp, input string tag);
    @(negedge clk); rd_addr_s = 3'(addr);
    @(negedge clk); chk(tag, 32'(rd_data_s), 32'(exp));
  endtask

  task automatic read_b(input int addr, input int exp, input string tag);
    @(negedge clk); rd_addr_b = 10'(addr);
    @(negedge clk); chk(tag, 32'(rd_data_b), 32'(exp));
  endtask

  task automatic status(input string tag, input int exp_done, input int exp_busy,
                        input int fl_b, input int fl_s, input int ov_b, input int ov_s);
    chk({tag, "_done_b"}, 32'(done_b), 32'(exp_done));
    chk({tag, "_done_s"}, 32'(done_s), 32'(exp_done));
    chk({tag, "_busy_b"}, 32'(busy_b), 32'(exp_busy));
    chk({tag, "_tready_s"}, 32'(tready_s), 32'(exp_busy));
    chk({tag, "_flen_b"}, 32'(flen_b), 32'(fl_b));
    chk({tag, "_flen_s"}, 32'(flen_s), 32'(fl_s));
    chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(ov_b));
    chk({tag, "_ovf_s"}, 32'(ovf_s), 32'(ov_s));
  endtask

  initial begin
    int cyc;

    // Reset state
    repeat (3) @(negedge clk);
    status("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_tready_b", 32'(tready_b), 0);
    chk("rst_rd_b", 32'(rd_data_b), 0);
    chk("rst_rd_s", 32'(rd_data_s), 0);
    reset = 1'b0;

    // Test 1: 8-beat frame, continuous valid; full-buffer tlast on the small instance
    arm_pulse();
    chk("t1_busy_after_arm", 32'(busy_b), 1);
    send(8, 0, 1'b0, 1'b1, cyc);
    status("t1", 1, 0, 8, 8, 0, 0);
    for (int i = 0; i < 8; i++) begin
      read_b(i, i, "t1_mem_b");
      read_s(i, i, "t1_mem_s");
    end

    // Test 2: 8-beat frame with random valid gaps
    arm_pulse();
    send(8, 16'h20, 1'b1, 1'b1, cyc);
    status("t2", 1, 0, 8, 8, 0, 0);
    for (int i = 0; i < 8; i++) begin
      read_b(i, 16'h20 + i, "t2_mem_b");
      read_s(i, 16'h20 + i, "t2_mem_s");
    end

    // Test 3: 12-beat frame overflows the 8-deep buffer, ready held throughout
    arm_pulse();
    send(12, 16'h40, 1'b0, 1'b1, cyc);
    chk("t3_cycles", 32'(cyc), 12);
    status("t3", 1, 0, 12, 8, 0, 1);
    for (int i = 0; i < 8; i++) read_s(i, 16'h40 + i, "t3_mem_s");
    read_b(11, 16'h4B, "t3_mem_b11");

    // Test 4: full frame clears overflow, then a single-beat frame
    arm_pulse();
    chk("t4_ovf_cleared", 32'(ovf_s), 0);
    send(8, 16'h60, 1'b0, 1'b1, cyc);
    status("t4a", 1, 0, 8, 8, 0, 0);
    arm_pulse();
    send(1, 16'h77, 1'b0, 1'b1, cyc);
    status("t4b", 1, 0, 1, 1, 0, 0);
    read_s(0, 16'h77, "t4_mem_s0");
    read_s(1, 16'h61, "t4_mem_s1");
    read_b(0, 16'h77, "t4_mem_b0");

    // Test 5: arm held through done does not restart; arm edge mid-capture ignored
    @(negedge clk); arm = 1'b1;
    send(3, 16'h80, 1'b0, 1'b1, cyc);
    @(negedge clk); tvalid = 1'b1; tdata = 16'h99;
    repeat (3) @(negedge clk);
    status("t5_held", 1, 0, 3, 3, 0, 0);
    tvalid = 1'b0;
    arm = 1'b0;
    @(negedge clk); arm = 1'b1;
    @(negedge clk);
    status("t5_rearm", 0, 1, 0, 0, 0, 0);
    send(2, 16'h90, 1'b0, 1'b0, cyc);
    arm = 1'b0;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    send(2, 16'h92, 1'b0, 1'b1, cyc);
    status("t5_frame", 1, 0, 4, 4, 0, 0);
    read_b(3, 16'h93, "t5_mem_b3");

    // Test 6a: reset after 3 accepted beats
    arm_pulse();
    send(3, 16'hA0, 1'b0, 1'b0, cyc);
    reset = 1'b1;
    @(negedge clk);
    status("t6_rst", 0, 0, 0, 0, 0, 0);
    chk("t6_rst_rd", 32'(rd_data_b), 0);
    reset = 1'b0;
    arm_pulse();
    send(1, 16'hB0, 1'b0, 1'b1, cyc);
    status("t6_after_rst", 1, 0, 1, 1, 0, 0);
    read_b(0, 16'hB0, "t6_mem_b0");

    // Test 6b: abort after 3 beats, coinciding with an accepted tlast beat
    arm_pulse();
    send(3, 16'hC0, 1'b0, 1'b0, cyc);
    tvalid = 1'b1; tdata = 16'hC3; tlast = 1'b1; abort = 1'b1;
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; abort = 1'b0;
    status("t6_abort", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    status("t6_abort_idle", 0, 0, 0, 0, 0, 0);
    read_b(3, 16'hC3, "t6_abort_beat");
    arm_pulse();
    send(2, 16'hD0, 1'b0, 1'b1, cyc);
    status("t6_fresh", 1, 0, 2, 2, 0, 0);
    read_b(0, 16'hD0, "t6_fresh_b0");
    read_s(1, 16'hD1, "t6_fresh_s1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
